fpu_postproc_arb: RTL and testbench
===================================

// Module: fpu_postproc_arb
// PURPOSE
//  Arbitrates the shared FPU post-processing datapath (shift correction, rounding, flags) between the
//  pipelined FMA and the iterative divsqrt unit. A one-entry skid buffer holds a divsqrt result that
//  loses arbitration. A registered issue stage drives the postproc op selects (FmaOp/DivOp) and the
//  destination tag. Sits between the fma/fdivsqrt outputs and the postprocessor in the FPU.
// PARAMETERS
//  P             cvw_t config  -  core configuration; only P.FLEN-independent fields used here
//  STARVE_LIMIT  4             -  cycles a buffered div may wait before it takes priority (1..15)
// PORTS
//  clk          in   1  core clock
//  reset        in   1  synchronous, active-high reset
//  FlushE       in   1  flush: discard all pending and issued work
//  FmaValid     in   1  FMA result ready for postproc this cycle
//  FmaRd        in   5  FMA destination register tag
//  FmaReady     out  1  FMA result accepted this cycle (FMA pipe must stall when low)
//  DivValid     in   1  divsqrt done, result ready for postproc
//  DivRd        in   5  divsqrt destination register tag
//  DivReady     out  1  divsqrt result accepted (skid buffer empty)
//  PostReady    in   1  downstream (writeback) accepts the issued op
//  PostValid    out  1  issue stage holds a valid op
//  PostFmaOp    out  1  issued op is FMA (drives postproc FmaOp)
//  PostDivOp    out  1  issued op is divsqrt (drives postproc DivOp)
//  PostRd       out  5  tag of issued op
//  DivStarved   out  1  buffered div has reached STARVE_LIMIT (debug/perf)
// BEHAVIOUR
//  - Reset/FlushE (sync, same-cycle sample): PostValid=0, PostFmaOp=0, PostDivOp=0, PostRd=0,
//    skid empty, wait counter=0, DivStarved=0. FmaReady/DivReady are combinational and are
//    0 in any cycle where reset or FlushE is high.
//  - Advance = ~PostValid | PostReady. When ~Advance: FmaReady=0, issue regs hold, skid holds.
//  - DivReady = skid empty & ~reset & ~FlushE. A div captured into skid when DivValid&DivReady and
//    it is not issued directly that cycle.
//  - Source states (postproc_src_t): PP_NONE, PP_FMA, PP_DIV. Grant per cycle when Advance:
//      skid full & starved      -> PP_DIV from skid, FmaReady=0
//      FmaValid                 -> PP_FMA, FmaReady=1
//      skid full                -> PP_DIV from skid
//      DivValid (skid empty)    -> PP_DIV bypass, skid stays empty
//      else                     -> PP_NONE, PostValid<=0
//  - FmaValid & DivValid same cycle, skid empty, not starved: FMA issues, div enters skid.
//  - Issue latency: one cycle grant-to-PostValid. Exactly one of PostFmaOp/PostDivOp set iff PostValid.
//  - Wait counter (4 bit): clears when skid empty or skid drains; increments each cycle skid is full
//    and not drained; saturates at STARVE_LIMIT. starved = (count == STARVE_LIMIT); DivStarved mirrors it.
//  - Skid drain and new div capture same cycle impossible (DivReady=0 while full); no overwrite.
//  - FMA result never dropped: FmaValid with FmaReady=0 must be held by the FMA pipe.
// CONFIGURATION
//  POSTPROC_DIV_STARVE_EN defined: starvation override as above.
//  Undefined: strict FMA priority; counter not built; DivStarved tied 0; a buffered div waits
//  until a cycle with ~FmaValid & Advance.
// STRUCTURE
//  cvw package: typedef enum logic [1:0] {PP_NONE, PP_FMA, PP_DIV} postproc_src_t;
//   localparam POSTPROC_TAG_W = 5.
//  Sub-module: fpu_postproc_skid (one-entry valid+tag buffer, load/drain/flush).
//  Grant logic, counter and issue registers (flopenr/flopr style) in this module.
// TESTING
//  1 FmaValid=1 for 3 cycles, PostReady=1 -> PostValid=1, PostFmaOp=1 cycles 2..4, PostRd tracks FmaRd.
//  2 FmaValid=1 & DivValid=1 (DivRd=7) same cycle -> FMA issued cycle+1, div in skid, DivReady=0,
//    div issued first cycle FmaValid=0 with PostRd=7.
//  3 STARVE_EN, STARVE_LIMIT=4, FmaValid held 1, div buffered -> DivStarved=1 after 4 cycles,
//    next grant PP_DIV with FmaReady=0, then FMA resumes; no FMA tag lost or duplicated.
//  4 PostReady=0 for 3 cycles with FMA issued -> PostRd stable, FmaReady=0, DivValid captured into
//    skid once, DivReady=0 afterwards.
//  5 FlushE with skid full and PostValid=1 -> next cycle PostValid=0, DivReady=1, counter=0.
//  6 reset asserted mid-stream -> all outputs 0 next edge; Ready outputs 0 while reset high.

Source files
------------

// File: rtl/fpu_postproc_arb_pkg.sv
// Shared types for the FPU post-processing arbiter: source select encoding and tag width.
package fpu_postproc_arb_pkg;
  localparam int POSTPROC_TAG_W = 5;

  typedef enum logic [1:0] {PP_NONE, PP_FMA, PP_DIV} postproc_src_t;
endpackage

// File: rtl/fpu_postproc_arb_if.sv
// Handshake bundle between the FMA/divsqrt producers, the arbiter and the postprocessor.
interface fpu_postproc_arb_if;
  import fpu_postproc_arb_pkg::*;

  logic                      FmaValid;
  logic [POSTPROC_TAG_W-1:0] FmaRd;
  logic                      FmaReady;
  logic                      DivValid;
  logic [POSTPROC_TAG_W-1:0] DivRd;
  logic                      DivReady;
  logic                      PostReady;
  logic                      PostValid;
  logic                      PostFmaOp;
  logic                      PostDivOp;
  logic [POSTPROC_TAG_W-1:0] PostRd;
  logic                      DivStarved;

  // master: the surrounding FPU (producers and writeback); slave: the arbiter
  modport master (
    output FmaValid, FmaRd, DivValid, DivRd, PostReady,
    input  FmaReady, DivReady, PostValid, PostFmaOp, PostDivOp, PostRd, DivStarved
  );

  modport slave (
    input  FmaValid, FmaRd, DivValid, DivRd, PostReady,
    output FmaReady, DivReady, PostValid, PostFmaOp, PostDivOp, PostRd, DivStarved
  );
endinterface

// File: rtl/fpu_postproc_skid.sv
// One-entry valid+tag buffer holding a divsqrt result that lost arbitration.
module fpu_postproc_skid
  import fpu_postproc_arb_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      load,
  input  logic                      drain,
  input  logic [POSTPROC_TAG_W-1:0] loadRd,
  output logic                      full,
  output logic [POSTPROC_TAG_W-1:0] rd
);

  // load and drain never coincide: the arbiter only accepts a div while empty
  always_ff @(posedge clk) begin
    if (reset | flush)  full <= 1'b0;
    else if (load)      full <= 1'b1;
    else if (drain)     full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) rd <= loadRd;
  end
endmodule

// File: rtl/fpu_postproc_arb.sv
// Arbitrates the shared FPU postprocessor between FMA and divsqrt with a registered issue stage.
// Optional: define POSTPROC_DIV_STARVE_EN to let a long-buffered div override FMA priority.
module fpu_postproc_arb
  import fpu_postproc_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                FlushE,
  fpu_postproc_arb_if.slave   bus
);

  logic                      kill;
  logic                      advance;
  logic                      divReady;
  logic                      divBypass;
  logic                      skidFull;
  logic                      skidLoad;
  logic                      skidDrain;
  logic                      starved;
  logic [POSTPROC_TAG_W-1:0] skidRd;
  logic [POSTPROC_TAG_W-1:0] grantRd;
  logic [POSTPROC_TAG_W-1:0] issueRd_p1;
  postproc_src_t             grantSrc;
  postproc_src_t             issueSrc_p1;

  assign kill     = reset | FlushE;
  assign advance  = (issueSrc_p1 == PP_NONE) | bus.PostReady;
  assign divReady = ~skidFull & ~kill;
  assign skidLoad = bus.DivValid & divReady & ~divBypass;

  fpu_postproc_skid u_skid (
    .clk    (clk),
    .reset  (reset),
    .flush  (FlushE),
    .load   (skidLoad),
    .drain  (skidDrain),
    .loadRd (bus.DivRd),
    .full   (skidFull),
    .rd     (skidRd)
  );

`ifdef POSTPROC_DIV_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] waitCnt;

  // counts cycles the buffered div has been passed over, holding at the limit
  always_ff @(posedge clk) begin
    if (kill | ~skidFull | skidDrain) waitCnt <= '0;
    else if (waitCnt != LIMIT)        waitCnt <= waitCnt + 4'd1;
  end

  assign starved = (waitCnt == LIMIT);
`else
  assign starved = 1'b0;
`endif

  // grant select: next state of the issue stage
  always_comb begin
    grantSrc  = PP_NONE;
    grantRd   = '0;
    skidDrain = 1'b0;
    divBypass = 1'b0;
    if (!kill && advance) begin
      if (skidFull && starved) begin
        grantSrc  = PP_DIV;
        grantRd   = skidRd;
        skidDrain = 1'b1;
      end else if (bus.FmaValid) begin
        grantSrc  = PP_FMA;
        grantRd   = bus.FmaRd;
      end else if (skidFull) begin
        grantSrc  = PP_DIV;
        grantRd   = skidRd;
        skidDrain = 1'b1;
      end else if (bus.DivValid) begin
        grantSrc  = PP_DIV;
        grantRd   = bus.DivRd;
        divBypass = 1'b1;
      end
    end
  end

  // ---- issue stage (p1) ----
  always_ff @(posedge clk) begin
    if (kill) begin
      issueSrc_p1 <= PP_NONE;
      issueRd_p1  <= '0;
    end else if (advance) begin
      issueSrc_p1 <= grantSrc;
      issueRd_p1  <= grantRd;
    end
  end

  always_comb begin
    bus.PostValid  = (issueSrc_p1 != PP_NONE);
    bus.PostFmaOp  = (issueSrc_p1 == PP_FMA);
    bus.PostDivOp  = (issueSrc_p1 == PP_DIV);
    bus.PostRd     = issueRd_p1;
    bus.FmaReady   = (grantSrc == PP_FMA);
    bus.DivReady   = divReady;
    bus.DivStarved = starved;
  end
endmodule

// File: tb/tb_fpu_postproc_arb.sv
// Directed bench for fpu_postproc_arb; the starvation scenario follows POSTPROC_DIV_STARVE_EN.
module tb_fpu_postproc_arb;
  logic clk = 1'b0;
  logic reset;
  logic FlushE;
  int   total = 0;
  int   bad   = 0;

  fpu_postproc_arb_if bus ();

  fpu_postproc_arb #(.STARVE_LIMIT(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .FlushE (FlushE),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.FmaValid  = 1'b0;
    bus.FmaRd     = '0;
    bus.DivValid  = 1'b0;
    bus.DivRd     = '0;
    bus.PostReady = 1'b1;
    FlushE        = 1'b0;
  endtask

  task automatic test_reset;
    bus.FmaValid = 1'b1; bus.FmaRd = 5'd2; bus.DivValid = 1'b1; bus.DivRd = 5'd4;
    #1;
    total++; if (bus.FmaReady !== 1'b0) begin bad++; $display("FAIL rst_fmaready: got %b want 0", bus.FmaReady); end
    total++; if (bus.DivReady !== 1'b0) begin bad++; $display("FAIL rst_divready: got %b want 0", bus.DivReady); end
    tick;
    total++; if (bus.PostValid !== 1'b0) begin bad++; $display("FAIL rst_postvalid: got %b want 0", bus.PostValid); end
    total++; if (bus.PostRd !== 5'd0) begin bad++; $display("FAIL rst_postrd: got %0d want 0", bus.PostRd); end
    total++; if ({bus.PostFmaOp, bus.PostDivOp, bus.DivStarved} !== 3'b000) begin bad++; $display("FAIL rst_ops: got %b want 000", {bus.PostFmaOp, bus.PostDivOp, bus.DivStarved}); end
    reset = 1'b0;
    idle();
    tick;
    total++; if (bus.PostValid !== 1'b0) begin bad++; $display("FAIL rst_release: got %b want 0", bus.PostValid); end
  endtask

  task automatic test_fma_stream;
    for (int i = 0; i < 3; i++) begin
      bus.FmaValid = 1'b1; bus.FmaRd = 5'(3 + i);
      #1;
      total++; if (bus.FmaReady !== 1'b1) begin bad++; $display("FAIL fma_ready[%0d]: got %b want 1", i, bus.FmaReady); end
      tick;
      total++; if ({bus.PostValid, bus.PostFmaOp, bus.PostDivOp} !== 3'b110) begin bad++; $display("FAIL fma_ops[%0d]: got %b want 110", i, {bus.PostValid, bus.PostFmaOp, bus.PostDivOp}); end
      total++; if (bus.PostRd !== 5'(3 + i)) begin bad++; $display("FAIL fma_rd[%0d]: got %0d want %0d", i, bus.PostRd, 3 + i); end
    end
    idle();
    tick;
    total++; if (bus.PostValid !== 1'b0) begin bad++; $display("FAIL fma_drain: got %b want 0", bus.PostValid); end
  endtask

  task automatic test_div_bypass;
    bus.DivValid = 1'b1; bus.DivRd = 5'd21;
    #1;
    total++; if (bus.DivReady !== 1'b1) begin bad++; $display("FAIL byp_ready: got %b want 1", bus.DivReady); end
    tick;
    total++; if ({bus.PostValid, bus.PostFmaOp, bus.PostDivOp} !== 3'b101) begin bad++; $display("FAIL byp_ops: got %b want 101", {bus.PostValid, bus.PostFmaOp, bus.PostDivOp}); end
    total++; if (bus.PostRd !== 5'd21) begin bad++; $display("FAIL byp_rd: got %0d want 21", bus.PostRd); end
    idle();
    #1;
    total++; if (bus.DivReady !== 1'b1) begin bad++; $display("FAIL byp_skid_empty: got %b want 1", bus.DivReady); end
    tick;
    total++; if (bus.PostValid !== 1'b0) begin bad++; $display("FAIL byp_nodup: got %b want 0", bus.PostValid); end
  endtask

  task automatic test_collision;
    bus.FmaValid = 1'b1; bus.FmaRd = 5'd10; bus.DivValid = 1'b1; bus.DivRd = 5'd7;
    #1;
    total++; if ({bus.FmaReady, bus.DivReady} !== 2'b11) begin bad++; $display("FAIL col_ready: got %b want 11", {bus.FmaReady, bus.DivReady}); end
    tick;
    total++; if (bus.PostFmaOp !== 1'b1 || bus.PostRd !== 5'd10) begin bad++; $display("FAIL col_fma0: got op=%b rd=%0d want op=1 rd=10", bus.PostFmaOp, bus.PostRd); end
    bus.DivValid = 1'b0; bus.FmaRd = 5'd11;
    #1;
    total++; if ({bus.FmaReady, bus.DivReady} !== 2'b10) begin bad++; $display("FAIL col_skidfull: got %b want 10", {bus.FmaReady, bus.DivReady}); end
    tick;
    total++; if (bus.PostFmaOp !== 1'b1 || bus.PostRd !== 5'd11) begin bad++; $display("FAIL col_fma1: got op=%b rd=%0d want op=1 rd=11", bus.PostFmaOp, bus.PostRd); end
    idle();
    tick;
    total++; if ({bus.PostValid, bus.PostDivOp} !== 2'b11 || bus.PostRd !== 5'd7) begin bad++; $display("FAIL col_div: got vd=%b rd=%0d want vd=11 rd=7", {bus.PostValid, bus.PostDivOp}, bus.PostRd); end
    #1;
    total++; if (bus.DivReady !== 1'b1) begin bad++; $display("FAIL col_drained: got %b want 1", bus.DivReady); end
    tick;
    total++; if (bus.PostValid !== 1'b0) begin bad++; $display("FAIL col_idle: got %b want 0", bus.PostValid); end
  endtask

  task automatic test_starve;
    bus.FmaValid = 1'b1; bus.FmaRd = 5'd1; bus.DivValid = 1'b1; bus.DivRd = 5'd20;
    tick;
    total++; if (bus.PostRd !== 5'd1) begin bad++; $display("FAIL stv_rd1: got %0d want 1", bus.PostRd); end
    bus.DivValid = 1'b0;
`ifdef POSTPROC_DIV_STARVE_EN
    for (int c = 1; c <= 4; c++) begin
      bus.FmaRd = 5'(c + 1);
      #1;
      total++; if ({bus.FmaReady, bus.DivStarved} !== 2'b10) begin bad++; $display("FAIL stv_wait[%0d]: got %b want 10", c, {bus.FmaReady, bus.DivStarved}); end
      tick;
      total++; if (bus.PostFmaOp !== 1'b1 || bus.PostRd !== 5'(c + 1)) begin bad++; $display("FAIL stv_fma[%0d]: got op=%b rd=%0d want op=1 rd=%0d", c, bus.PostFmaOp, bus.PostRd, c + 1); end
    end
    bus.FmaRd = 5'd6;
    #1;
    total++; if ({bus.FmaReady, bus.DivStarved} !== 2'b01) begin bad++; $display("FAIL stv_starved: got %b want 01", {bus.FmaReady, bus.DivStarved}); end
    tick;
    total++; if (bus.PostDivOp !== 1'b1 || bus.PostRd !== 5'd20) begin bad++; $display("FAIL stv_div: got op=%b rd=%0d want op=1 rd=20", bus.PostDivOp, bus.PostRd); end
    total++; if (bus.DivStarved !== 1'b0) begin bad++; $display("FAIL stv_clear: got %b want 0", bus.DivStarved); end
    #1;
    total++; if (bus.FmaReady !== 1'b1) begin bad++; $display("FAIL stv_resume: got %b want 1", bus.FmaReady); end
    tick;
    total++; if (bus.PostFmaOp !== 1'b1 || bus.PostRd !== 5'd6) begin bad++; $display("FAIL stv_fma6: got op=%b rd=%0d want op=1 rd=6", bus.PostFmaOp, bus.PostRd); end
    idle();
    tick;
    total++; if (bus.PostValid !== 1'b0) begin bad++; $display("FAIL stv_idle: got %b want 0", bus.PostValid); end
`else
    for (int c = 1; c <= 6; c++) begin
      bus.FmaRd = 5'(c + 1);
      #1;
      total++; if ({bus.FmaReady, bus.DivReady, bus.DivStarved} !== 3'b100) begin bad++; $display("FAIL strict_wait[%0d]: got %b want 100", c, {bus.FmaReady, bus.DivReady, bus.DivStarved}); end
      tick;
      total++; if (bus.PostFmaOp !== 1'b1 || bus.PostRd !== 5'(c + 1)) begin bad++; $display("FAIL strict_fma[%0d]: got op=%b rd=%0d want op=1 rd=%0d", c, bus.PostFmaOp, bus.PostRd, c + 1); end
    end
    idle();
    tick;
    total++; if (bus.PostDivOp !== 1'b1 || bus.PostRd !== 5'd20) begin bad++; $display("FAIL strict_div: got op=%b rd=%0d want op=1 rd=20", bus.PostDivOp, bus.PostRd); end
    tick;
    total++; if (bus.PostValid !== 1'b0) begin bad++; $display("FAIL strict_idle: got %b want 0", bus.PostValid); end
`endif
  endtask

  task automatic test_backpressure;
    bus.FmaValid = 1'b1; bus.FmaRd = 5'd12;
    tick;
    total++; if (bus.PostRd !== 5'd12) begin bad++; $display("FAIL bp_issue: got %0d want 12", bus.PostRd); end
    bus.PostReady = 1'b0; bus.FmaRd = 5'd13; bus.DivValid = 1'b1; bus.DivRd = 5'd9;
    #1;
    total++; if ({bus.FmaReady, bus.DivReady} !== 2'b01) begin bad++; $display("FAIL bp_capture: got %b want 01", {bus.FmaReady, bus.DivReady}); end
    tick;
    bus.DivValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({bus.FmaReady, bus.DivReady} !== 2'b00) begin bad++; $display("FAIL bp_hold[%0d]: got %b want 00", i, {bus.FmaReady, bus.DivReady}); end
      tick;
      total++; if (bus.PostRd !== 5'd12 || bus.PostFmaOp !== 1'b1) begin bad++; $display("FAIL bp_stable[%0d]: got rd=%0d op=%b want rd=12 op=1", i, bus.PostRd, bus.PostFmaOp); end
    end
    bus.PostReady = 1'b1;
    #1;
    total++; if (bus.FmaReady !== 1'b1) begin bad++; $display("FAIL bp_release: got %b want 1", bus.FmaReady); end
    tick;
    total++; if (bus.PostRd !== 5'd13) begin bad++; $display("FAIL bp_fma13: got %0d want 13", bus.PostRd); end
    idle();
    tick;
    total++; if (bus.PostDivOp !== 1'b1 || bus.PostRd !== 5'd9) begin bad++; $display("FAIL bp_div9: got op=%b rd=%0d want op=1 rd=9", bus.PostDivOp, bus.PostRd); end
    tick;
    total++; if (bus.PostValid !== 1'b0) begin bad++; $display("FAIL bp_once: got %b want 0", bus.PostValid); end
  endtask

  task automatic test_flush;
    bus.FmaValid = 1'b1; bus.FmaRd = 5'd14; bus.DivValid = 1'b1; bus.DivRd = 5'd15;
    tick;
    total++; if (bus.PostValid !== 1'b1) begin bad++; $display("FAIL fl_pre: got %b want 1", bus.PostValid); end
    bus.FmaValid = 1'b0; bus.DivValid = 1'b0; FlushE = 1'b1;
    #1;
    total++; if ({bus.FmaReady, bus.DivReady} !== 2'b00) begin bad++; $display("FAIL fl_ready: got %b want 00", {bus.FmaReady, bus.DivReady}); end
    tick;
    total++; if ({bus.PostValid, bus.PostFmaOp, bus.PostDivOp} !== 3'b000 || bus.PostRd !== 5'd0) begin bad++; $display("FAIL fl_clear: got %b rd=%0d want 000 rd=0", {bus.PostValid, bus.PostFmaOp, bus.PostDivOp}, bus.PostRd); end
    FlushE = 1'b0;
    #1;
    total++; if ({bus.DivReady, bus.DivStarved} !== 2'b10) begin bad++; $display("FAIL fl_skid: got %b want 10", {bus.DivReady, bus.DivStarved}); end
    tick;
    total++; if (bus.PostValid !== 1'b0) begin bad++; $display("FAIL fl_noissue: got %b want 0", bus.PostValid); end
  endtask

  task automatic test_reset_mid;
    bus.FmaValid = 1'b1; bus.FmaRd = 5'd17; bus.DivValid = 1'b1; bus.DivRd = 5'd18;
    tick;
    total++; if (bus.PostRd !== 5'd17) begin bad++; $display("FAIL mr_pre: got %0d want 17", bus.PostRd); end
    reset = 1'b1;
    #1;
    total++; if ({bus.FmaReady, bus.DivReady} !== 2'b00) begin bad++; $display("FAIL mr_ready: got %b want 00", {bus.FmaReady, bus.DivReady}); end
    tick;
    total++; if ({bus.PostValid, bus.PostFmaOp, bus.PostDivOp, bus.DivStarved} !== 4'b0000 || bus.PostRd !== 5'd0) begin bad++; $display("FAIL mr_clear: got %b rd=%0d want 0000 rd=0", {bus.PostValid, bus.PostFmaOp, bus.PostDivOp, bus.DivStarved}, bus.PostRd); end
    reset = 1'b0;
    idle();
    tick;
    total++; if (bus.PostValid !== 1'b0) begin bad++; $display("FAIL mr_skid: got %b want 0", bus.PostValid); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick;
    test_reset();
    test_fma_stream();
    test_div_bypass();
    test_collision();
    test_starve();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
